// File: rtl/instr_mem_responder_if.sv
// Fetch/program bus between cpuController and the instruction memory responder.
// The master drives PC and the load port; the slave returns IR and status.
interface instr_mem_responder_if;
    logic [15:0] PC;
    logic [15:0] IR;
    logic        IR_valid;
    logic        fault;
    logic        busy;
    logic        ld_mode;
    logic        ld_we;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;

    modport master (
        output PC, ld_mode, ld_we, ld_addr, ld_data,
        input  IR, IR_valid, fault, busy
    );

    modport slave (
        input  PC, ld_mode, ld_we, ld_addr, ld_data,
        output IR, IR_valid, fault, busy
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-side responder: returns mem[PC] a fixed RD_LAT edges after the PC
// is accepted, with a program port that suspends fetching while active.
module instr_mem_responder #(
    parameter int          ADDR_W   = 8,
    parameter int          RD_LAT   = 1,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input logic                  clk,
    input logic                  reset,
    instr_mem_responder_if.slave bus
);
    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] pc_q_r;
    logic [2:0]  lat_cnt_r;
    logic [15:0] ir_r;
    logic        ir_valid_r;
    logic        fault_r;
    logic        busy_r;
    logic [15:0] mem [DEPTH];

    logic        pc_changed_s;
    logic        pc_in_range_s;
    logic [15:0] rd_word_s;

    // The full 16-bit address is compared, so upper bits never alias into the store.
    function automatic logic in_range(input logic [15:0] addr);
        in_range = ({16'd0, addr} < (32'd1 << ADDR_W));
    endfunction

    // Read-side decode for the latched fetch address.
    always_comb begin
        pc_changed_s  = (bus.PC != pc_q_r);
        pc_in_range_s = in_range(pc_q_r);
        if (pc_in_range_s) begin
            rd_word_s = mem[pc_q_r[ADDR_W-1:0]];
        end else begin
            rd_word_s = NOP_WORD;
        end
    end

    // Instruction store: written only from LOAD, contents survive reset.
    always_ff @(posedge clk) begin
        if ((state_r == S_LOAD) && bus.ld_we && in_range(bus.ld_addr)) begin
            mem[bus.ld_addr[ADDR_W-1:0]] <= bus.ld_data;
        end
    end

    // Fetch/load sequencer with registered IR, IR_valid, fault and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            pc_q_r     <= 16'd0;
            lat_cnt_r  <= 3'd0;
            ir_r       <= 16'd0;
            ir_valid_r <= 1'b0;
            fault_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else if (bus.ld_mode) begin
            // Program mode wins over any fetch activity, including a PC change.
            state_r    <= S_LOAD;
            ir_valid_r <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    pc_q_r    <= bus.PC;
                    lat_cnt_r <= LAT_LOAD;
                    state_r   <= S_WAIT;
                    busy_r    <= 1'b1;
                end
                S_WAIT: begin
                    if (pc_changed_s) begin
                        pc_q_r    <= bus.PC;
                        lat_cnt_r <= LAT_LOAD;
                    end else if (lat_cnt_r <= 3'd1) begin
                        lat_cnt_r  <= 3'd0;
                        ir_r       <= rd_word_s;
                        fault_r    <= ~pc_in_range_s;
                        ir_valid_r <= 1'b1;
                        state_r    <= S_VALID;
                        busy_r     <= 1'b0;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 3'd1;
                    end
                end
                S_VALID: begin
                    if (pc_changed_s) begin
                        pc_q_r     <= bus.PC;
                        lat_cnt_r  <= LAT_LOAD;
                        ir_valid_r <= 1'b0;
                        state_r    <= S_WAIT;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= S_VALID;
                    end
                end
                S_LOAD: begin
                    // Leaving LOAD goes through IDLE so the current PC is refetched.
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= S_IDLE;
                    ir_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IR       = ir_r;
    assign bus.IR_valid = ir_valid_r;
    assign bus.fault    = fault_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: two responders (RD_LAT=1 and RD_LAT=3) share one stimulus stream;
// expected words come from an array model of the store and the range rule.
module tb_instr_mem_responder;
    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic        ld_mode;
    logic        ld_we;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mdl [256];
    logic [16:0] q1 [$];
    logic [16:0] q3 [$];
    logic [15:0] cur, tmp, nxt;

    instr_mem_responder_if b1 ();
    instr_mem_responder_if b3 ();

    assign b1.PC = pc;      assign b3.PC = pc;
    assign b1.ld_mode = ld_mode; assign b3.ld_mode = ld_mode;
    assign b1.ld_we = ld_we;     assign b3.ld_we = ld_we;
    assign b1.ld_addr = ld_addr; assign b3.ld_addr = ld_addr;
    assign b1.ld_data = ld_data; assign b3.ld_data = ld_data;

    instr_mem_responder #(.ADDR_W(8), .RD_LAT(1), .NOP_WORD(16'h0000)) u1 (
        .clk(clk), .reset(reset), .bus(b1.slave));
    instr_mem_responder #(.ADDR_W(8), .RD_LAT(3), .NOP_WORD(16'h0000)) u3 (
        .clk(clk), .reset(reset), .bus(b3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input int act, input int exp, input string name);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {fault, IR} for a fetch of address a, straight from the range rule.
    function automatic logic [16:0] exp_of(input logic [15:0] a);
        if (a < 16'd256) exp_of = {1'b0, mdl[a[7:0]]};
        else             exp_of = {1'b1, 16'h0000};
    endfunction

    function automatic logic [15:0] rand_pc();
        if ($urandom_range(0, 3) == 0) rand_pc = 16'h0100 + 16'($urandom_range(0, 16'hFEFF));
        else                           rand_pc = 16'($urandom_range(0, 15));
    endfunction

    task automatic push(input logic [15:0] a);
        q1.push_back(exp_of(a));
        q3.push_back(exp_of(a));
    endtask

    task automatic ld_write(input logic [15:0] a, input logic [15:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        if (a < 16'd256) mdl[a[7:0]] = d;
    endtask

    // Counts edges until each responder shows IR_valid and checks the counts.
    task automatic wait_both(input int e1, input int e3, input string tag);
        int c1 = -1;
        int c3 = -1;
        for (int i = 1; i <= 40 && (c1 < 0 || c3 < 0); i++) begin
            tick();
            if (c1 < 0 && b1.IR_valid === 1'b1) c1 = i;
            if (c3 < 0 && b3.IR_valid === 1'b1) c3 = i;
        end
        check(c1, e1, {tag, "_edges_lat1"});
        check(c3, e3, {tag, "_edges_lat3"});
    endtask

    task automatic fetch(input logic [15:0] a, input string tag);
        pc = a;
        push(a);
        wait_both(2, 4, tag);
        cur = a;
    endtask

    task automatic check_cleared(input string tag);
        check(int'(b1.IR), 0, {tag, "_ir1"});       check(int'(b3.IR), 0, {tag, "_ir3"});
        check(int'(b1.IR_valid), 0, {tag, "_v1"});  check(int'(b3.IR_valid), 0, {tag, "_v3"});
        check(int'(b1.fault), 0, {tag, "_f1"});     check(int'(b3.fault), 0, {tag, "_f3"});
        check(int'(b1.busy), 0, {tag, "_busy1"});   check(int'(b3.busy), 0, {tag, "_busy3"});
    endtask

    // Monitor: every rising IR_valid is one delivery and must match the queue head.
    initial begin
        logic pv1, pv3;
        logic [16:0] e;
        pv1 = 1'b0;
        pv3 = 1'b0;
        forever begin
            @(negedge clk);
            if (b1.IR_valid === 1'b1 && !pv1) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL deliver_lat1: unexpected word %h", b1.IR);
                end else begin
                    e = q1.pop_front();
                    if ({b1.fault, b1.IR} !== e) begin
                        n_err++;
                        $display("FAIL deliver_lat1: got fault=%b IR=%h expected fault=%b IR=%h",
                                 b1.fault, b1.IR, e[16], e[15:0]);
                    end
                end
            end
            if (b3.IR_valid === 1'b1 && !pv3) begin
                n_cmp++;
                if (q3.size() == 0) begin
                    n_err++;
                    $display("FAIL deliver_lat3: unexpected word %h", b3.IR);
                end else begin
                    e = q3.pop_front();
                    if ({b3.fault, b3.IR} !== e) begin
                        n_err++;
                        $display("FAIL deliver_lat3: got fault=%b IR=%h expected fault=%b IR=%h",
                                 b3.fault, b3.IR, e[16], e[15:0]);
                    end
                end
            end
            pv1 = (b1.IR_valid === 1'b1);
            pv3 = (b3.IR_valid === 1'b1);
        end
    end

    initial begin
        pc = 16'd0; ld_mode = 1'b1; ld_we = 1'b0; ld_addr = 16'd0; ld_data = 16'd0;
        reset = 1'b0; cur = 16'd0;
        #2 reset = 1'b1;
        #1 check_cleared("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check(int'(b1.IR_valid), 0, "load_v1"); check(int'(b3.IR_valid), 0, "load_v3");
        check(int'(b1.busy), 1, "load_busy1");  check(int'(b3.busy), 1, "load_busy3");

        ld_write(16'd0, 16'h8006);
        ld_write(16'd1, 16'h1234);
        ld_write(16'd2, 16'hABCD);
        for (int i = 3; i < 16; i++) ld_write(16'(i), 16'($urandom));
        for (int i = 0; i < 3; i++) ld_write(16'h0100 + 16'($urandom_range(0, 16'hFEFF)), 16'($urandom));
        ld_we = 1'b0;

        // Exit LOAD: one edge to IDLE, one to accept PC, then RD_LAT.
        pc = 16'd0; ld_mode = 1'b0; push(16'd0);
        wait_both(3, 5, "boot");
        cur = 16'd0;

        pc = 16'd1; push(16'd1);
        tick();
        check(int'(b1.IR_valid), 0, "seq_gap_v1");
        check(int'(b1.IR), 16'h8006, "seq_ir_held1");
        wait_both(1, 3, "seq1");
        fetch(16'd2, "seq2");

        // Change PC one edge into WAIT: the first word must never appear.
        pc = 16'd0;
        tick();
        check(int'(b1.IR_valid), 0, "restart_v1"); check(int'(b3.IR_valid), 0, "restart_v3");
        pc = 16'd2; push(16'd2);
        wait_both(2, 4, "restart");
        cur = 16'd2;

        fetch(16'h0100, "oor");
        fetch(16'd1, "oor_back");

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                tmp = rand_pc();
                while (tmp == cur) tmp = rand_pc();
                pc = tmp;
                tick();
                cur = tmp;
            end
            nxt = rand_pc();
            while (nxt == cur) nxt = rand_pc();
            fetch(nxt, "rand");
        end

        // Async reset between edges while a fetch is in flight.
        pc = (cur == 16'd0) ? 16'd2 : 16'd0;
        tick();
        #2 reset = 1'b1;
        #1 check_cleared("async_reset");
        pc = 16'd1;
        #3 reset = 1'b0;
        push(16'd1);
        wait_both(2, 4, "after_reset");
        cur = 16'd1;

        // Overwrite the word being presented; exit must refetch it.
        ld_mode = 1'b1;
        tick();
        check(int'(b1.IR_valid), 0, "reload_v1"); check(int'(b3.IR_valid), 0, "reload_v3");
        check(int'(b1.busy), 1, "reload_busy1");  check(int'(b3.busy), 1, "reload_busy3");
        ld_write(16'h0200, 16'hDEAD);
        ld_write(16'd1, 16'h5555);
        ld_we = 1'b0; ld_mode = 1'b0;
        push(16'd1);
        wait_both(3, 5, "refetch");
        fetch(16'd0, "no_alias");

        // ld_we outside LOAD must not write.
        ld_we = 1'b1; ld_addr = 16'd2; ld_data = 16'hFFFF;
        tick(); tick(); tick();
        ld_we = 1'b0;
        fetch(16'd2, "we_ignored");

        tick(); tick();
        check(q1.size(), 0, "queue_left_lat1");
        check(q3.size(), 0, "queue_left_lat3");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
